// File: rtl/test_pattern_gen_pkg.sv
// Shared pattern codes, colour constants and helpers for the test-pattern source.
package test_pattern_gen_pkg;

    typedef enum logic [2:0] {
        PAT_SOLID    = 3'd0,
        PAT_BARS     = 3'd1,
        PAT_CHECKER  = 3'd2,
        PAT_GRADIENT = 3'd3,
        PAT_BOX      = 3'd4,
        PAT_FLASH    = 3'd5
    } pattern_e;

    typedef enum logic {
        DirPos = 1'b0,
        DirNeg = 1'b1
    } dir_e;

    localparam logic [23:0] COL_WHITE = 24'hFFFFFF;
    localparam logic [23:0] COL_BLACK = 24'h000000;
    localparam logic [23:0] COL_NAVY  = 24'h000080;

    localparam int PIPE_LATENCY = 2;

    // Colour-bar table, left to right.
    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = COL_WHITE;
            3'd1:    c = 24'hFFFF00;
            3'd2:    c = 24'h00FFFF;
            3'd3:    c = 24'h00FF00;
            3'd4:    c = 24'hFF00FF;
            3'd5:    c = 24'hFF0000;
            3'd6:    c = 24'h0000FF;
            default: c = COL_BLACK;
        endcase
        return c;
    endfunction

    // Unused codes fall back to the solid pattern.
    function automatic pattern_e pattern_from_code(input logic [2:0] code);
        return (code > 3'd5) ? PAT_SOLID : pattern_e'(code);
    endfunction

endpackage

// File: rtl/test_pattern_gen_box_tracker.sv
// Bouncing-box position: moves BoxStep pixels per frame on each axis and reflects at the edges.
module test_pattern_gen_box_tracker
    import test_pattern_gen_pkg::*;
#(
    parameter int  HRes    = 720,
    parameter int  VRes    = 480,
    parameter int  BoxSize = 32,
    parameter int  BoxStep = 2,
    localparam int XW      = $clog2(HRes),
    localparam int YW      = $clog2(VRes)
) (
    input  logic          pixelClock,
    input  logic          resetN,
    input  logic          frame_end_i,
    output logic [XW-1:0] box_x_o,
    output logic [YW-1:0] box_y_o
);
    logic [XW-1:0] bx_q, bx_d;
    logic [YW-1:0] by_q, by_d;
    dir_e          dx_q, dx_d, dy_q, dy_d;

    always_comb begin
        bx_d = bx_q;
        by_d = by_q;
        dx_d = dx_q;
        dy_d = dy_q;
        if (frame_end_i) begin
            if (dx_q == DirPos) begin
                if (int'(bx_q) + BoxStep + BoxSize > HRes) begin
                    bx_d = XW'(HRes - BoxSize);
                    dx_d = DirNeg;
                end else begin
                    bx_d = bx_q + XW'(BoxStep);
                end
            end else begin
                if (int'(bx_q) < BoxStep) begin
                    bx_d = '0;
                    dx_d = DirPos;
                end else begin
                    bx_d = bx_q - XW'(BoxStep);
                end
            end
            if (dy_q == DirPos) begin
                if (int'(by_q) + BoxStep + BoxSize > VRes) begin
                    by_d = YW'(VRes - BoxSize);
                    dy_d = DirNeg;
                end else begin
                    by_d = by_q + YW'(BoxStep);
                end
            end else begin
                if (int'(by_q) < BoxStep) begin
                    by_d = '0;
                    dy_d = DirPos;
                end else begin
                    by_d = by_q - YW'(BoxStep);
                end
            end
        end
    end

    always_ff @(posedge pixelClock or negedge resetN) begin
        if (!resetN) begin
            bx_q <= '0;
            by_q <= '0;
            dx_q <= DirPos;
            dy_q <= DirPos;
        end else begin
            bx_q <= bx_d;
            by_q <= by_d;
            dx_q <= dx_d;
            dy_q <= dy_d;
        end
    end

    assign box_x_o = bx_q;
    assign box_y_o = by_q;

endmodule

// File: rtl/test_pattern_gen.sv
// RGB888 test-pattern source for hdmi_tx; the two-stage pipeline is hidden by a 2-pixel look-ahead.
module test_pattern_gen
    import test_pattern_gen_pkg::*;
#(
    parameter int          horizontalResolution = 720,
    parameter int          verticalResolution   = 480,
    parameter int          CHECK_LOG2           = 4,
    parameter int          BOX_SIZE             = 32,
    parameter int          BOX_STEP             = 2,
    parameter logic [23:0] SOLID_RGB            = 24'hFF8000,
    localparam int         HW                   = $clog2(horizontalResolution) + 1,
    localparam int         VW                   = $clog2(verticalResolution) + 1
) (
    input  logic                 pixelClock,
    input  logic                 resetN,
    input  logic signed [HW-1:0] hPosCounter,
    input  logic signed [VW-1:0] vPosCounter,
    input  logic [2:0]           patternSelect,
    output logic [7:0]           redByte,
    output logic [7:0]           greenByte,
    output logic [7:0]           blueByte,
    output logic [2:0]           activePattern,
    output logic [15:0]          frameCount
);
    localparam int                 XW    = HW - 1;
    localparam int                 YW    = VW - 1;
    localparam int                 BAR_W = horizontalResolution / 8;
    localparam logic signed [HW:0] XEnd  = (HW + 1)'(horizontalResolution);
    localparam logic signed [VW:0] YEnd  = (VW + 1)'(verticalResolution);
    localparam logic [HW-1:0]      HLast = HW'(horizontalResolution - 1);
    localparam logic [VW-1:0]      VLast = VW'(verticalResolution - 1);

    logic [1:0]         rst_sync_q;
    logic               rst_n;
    logic               frame_end;
    logic signed [HW:0] x;
    logic signed [VW:0] y;
    logic               blank;
    logic [2:0]         bar_idx;
    logic [XW-1:0]      box_x;
    logic [YW-1:0]      box_y;
    logic signed [HW:0] box_x0, box_x1;
    logic signed [VW:0] box_y0, box_y1;
    logic               in_box;
    logic [23:0]        raw_rgb;
    pattern_e           active_q, active_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic [23:0]        s1_rgb_q, out_rgb_q;

    // Reset asserts asynchronously but releases on a clock edge.
    always_ff @(posedge pixelClock or negedge resetN) begin
        if (!resetN) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n     = rst_sync_q[1];
    assign frame_end = (hPosCounter == HLast) && (vPosCounter == VLast);

    // Stage 1 works on the pixel that reaches the output PIPE_LATENCY cycles later.
    assign x     = {hPosCounter[HW-1], hPosCounter} + (HW + 1)'(PIPE_LATENCY);
    assign y     = {vPosCounter[VW-1], vPosCounter};
    assign blank = x[HW] | y[VW] | (x >= XEnd) | (y >= YEnd);

    always_comb begin
        bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (x >= $signed((HW + 1)'(k * BAR_W))) begin
                bar_idx = 3'(k);
            end
        end
    end

    test_pattern_gen_box_tracker #(
        .HRes    (horizontalResolution),
        .VRes    (verticalResolution),
        .BoxSize (BOX_SIZE),
        .BoxStep (BOX_STEP)
    ) u_box (
        .pixelClock  (pixelClock),
        .resetN      (rst_n),
        .frame_end_i (frame_end),
        .box_x_o     (box_x),
        .box_y_o     (box_y)
    );

    assign box_x0 = $signed({2'b00, box_x});
    assign box_y0 = $signed({2'b00, box_y});
    assign box_x1 = box_x0 + $signed((HW + 1)'(BOX_SIZE));
    assign box_y1 = box_y0 + $signed((VW + 1)'(BOX_SIZE));
    assign in_box = (x >= box_x0) && (x < box_x1) && (y >= box_y0) && (y < box_y1);

    always_comb begin
        raw_rgb = COL_BLACK;
        case (active_q)
            PAT_SOLID:    raw_rgb = SOLID_RGB;
            PAT_BARS:     raw_rgb = bar_colour(bar_idx);
            PAT_CHECKER:  raw_rgb = (x[CHECK_LOG2] ^ y[CHECK_LOG2]) ? COL_WHITE : COL_BLACK;
            PAT_GRADIENT: raw_rgb = {x[7:0], y[7:0], frame_cnt_q[7:0]};
            PAT_BOX:      raw_rgb = in_box ? COL_WHITE : COL_NAVY;
            PAT_FLASH:    raw_rgb = frame_cnt_q[5] ? COL_WHITE : COL_BLACK;
            default:      raw_rgb = COL_BLACK;
        endcase
        if (blank) begin
            raw_rgb = COL_BLACK;
        end
    end

    // Frame-level state only changes on the frame-end pixel, so a frame never tears.
    always_comb begin
        active_d    = active_q;
        frame_cnt_d = frame_cnt_q;
        if (frame_end) begin
            active_d    = pattern_from_code(patternSelect);
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge pixelClock or negedge rst_n) begin
        if (!rst_n) begin
            active_q    <= PAT_SOLID;
            frame_cnt_q <= '0;
            s1_rgb_q    <= '0;
            out_rgb_q   <= '0;
        end else begin
            active_q    <= active_d;
            frame_cnt_q <= frame_cnt_d;
            s1_rgb_q    <= raw_rgb;
            out_rgb_q   <= s1_rgb_q;
        end
    end

    assign redByte       = out_rgb_q[23:16];
    assign greenByte     = out_rgb_q[15:8];
    assign blueByte      = out_rgb_q[7:0];
    assign activePattern = active_q;
    assign frameCount    = frame_cnt_q;

endmodule
